// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and widths for the canal lock sequencer
package lock_pkg;

  localparam int LEVEL_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    ADJ_IN,
    OPEN_IN,
    CLOSE_IN,
    ADJ_OUT,
    OPEN_OUT,
    CLOSE_OUT
  } state_t;

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

endpackage

// File: rtl/water_level_ctr.sv
// rtl/water_level_ctr.sv - chamber water level with pump step prescaler and saturation
module water_level_ctr
  import lock_pkg::*;
#(
  parameter int LEVEL_MAX   = 63,
  parameter int STEP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fill_en,
  input  logic               drain_en,
  output logic [LEVEL_W-1:0] level,
  output logic [LEVEL_W-1:0] level_nxt
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(LEVEL_MAX);

  logic [SW-1:0]      r_step;
  logic [LEVEL_W-1:0] r_level;
  logic               w_pump;
  logic               w_step;

  assign w_pump = fill_en | drain_en;
  assign w_step = w_pump && (r_step == STEP_LAST);

  // level_nxt lets the sequencer shut the pump off on the same edge the target is reached
  always_comb begin
    level_nxt = r_level;
    if (w_step && fill_en && (r_level != LVL_MAX)) begin
      level_nxt = r_level + LEVEL_W'(1);
    end else if (w_step && drain_en && (r_level != '0)) begin
      level_nxt = r_level - LEVEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step  <= '0;
      r_level <= '0;
    end else begin
      r_level <= level_nxt;
      r_step  <= (w_pump && !w_step) ? r_step + SW'(1) : '0;
    end
  end

  assign level = r_level;

endmodule

// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - interlocked fill/drain, gate and boat handoff sequencer for one lock chamber
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int LEVEL_MAX   = 63,
  parameter int HIGH_THRESH = 48,
  parameter int LOW_THRESH  = 2,
  parameter int STEP_CYCLES = 4,
  parameter int GATE_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up_req,
  input  logic               down_req,
  input  logic               boat_in,
  input  logic               boat_out,
  output logic               gate1_open,
  output logic               gate2_open,
  output logic               fill_en,
  output logic               drain_en,
  output logic [LEVEL_W-1:0] water_level,
  output logic               occupied,
  output logic               up_grant,
  output logic               down_grant
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] HI = LEVEL_W'(HIGH_THRESH);
  localparam logic [LEVEL_W-1:0] LO = LEVEL_W'(LOW_THRESH);

  state_t             r_state, w_ns;
  dir_t               r_dir, w_dir_nxt;
  logic               r_occ, w_occ_nxt;
  logic [GW-1:0]      r_gcnt;
  logic               r_gate1, r_gate2, r_fill, r_drain, r_up_grant, r_down_grant;
  logic [LEVEL_W-1:0] w_level, w_lvl_nxt;
  logic               w_req, w_in_ok, w_out_ok, w_gate_done, w_closing;
  logic               w_fill_side, w_drain_side;

  water_level_ctr #(
    .LEVEL_MAX  (LEVEL_MAX),
    .STEP_CYCLES(STEP_CYCLES)
  ) u_level (
    .clk      (clk),
    .reset    (reset),
    .fill_en  (r_fill),
    .drain_en (r_drain),
    .level    (w_level),
    .level_nxt(w_lvl_nxt)
  );

  assign w_req       = (r_dir == UP) ? up_req : down_req;
  assign w_in_ok     = (r_dir == UP) ? (w_level >= HI) : (w_level <= LO);
  assign w_out_ok    = (r_dir == UP) ? (w_level <= LO) : (w_level >= HI);
  assign w_gate_done = (r_gcnt == GATE_LAST);

  always_comb begin
    w_ns      = r_state;
    w_dir_nxt = r_dir;
    w_occ_nxt = r_occ;
    case (r_state)
      IDLE: begin
        // r_dir doubles as last_dir here: on a tie serve the side not served last
        if (up_req && down_req) begin
          w_dir_nxt = (r_dir == UP) ? DOWN : UP;
          w_ns      = ADJ_IN;
        end else if (up_req) begin
          w_dir_nxt = UP;
          w_ns      = ADJ_IN;
        end else if (down_req) begin
          w_dir_nxt = DOWN;
          w_ns      = ADJ_IN;
        end
      end
      ADJ_IN:   if (w_in_ok) w_ns = OPEN_IN;
      OPEN_IN: begin
        if (boat_in) begin
          w_occ_nxt = 1'b1;
          w_ns      = CLOSE_IN;
        end else if (!w_req) begin
          w_ns = CLOSE_IN;
        end
      end
      CLOSE_IN: if (w_gate_done) w_ns = r_occ ? ADJ_OUT : IDLE;
      ADJ_OUT:  if (w_out_ok) w_ns = OPEN_OUT;
      OPEN_OUT: begin
        if (boat_out) begin
          w_occ_nxt = 1'b0;
          w_ns      = CLOSE_OUT;
        end
      end
      CLOSE_OUT: if (w_gate_done) w_ns = IDLE;
      default:   w_ns = IDLE;
    endcase
  end

  assign w_closing    = (w_ns == r_state) && ((r_state == CLOSE_IN) || (r_state == CLOSE_OUT));
  assign w_fill_side  = ((w_ns == ADJ_IN) && (w_dir_nxt == UP)) || ((w_ns == ADJ_OUT) && (w_dir_nxt == DOWN));
  assign w_drain_side = ((w_ns == ADJ_IN) && (w_dir_nxt == DOWN)) || ((w_ns == ADJ_OUT) && (w_dir_nxt == UP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_dir        <= DOWN;
      r_occ        <= 1'b0;
      r_gcnt       <= '0;
      r_gate1      <= 1'b0;
      r_gate2      <= 1'b0;
      r_fill       <= 1'b0;
      r_drain      <= 1'b0;
      r_up_grant   <= 1'b0;
      r_down_grant <= 1'b0;
    end else begin
      r_state      <= w_ns;
      r_dir        <= w_dir_nxt;
      r_occ        <= w_occ_nxt;
      r_gcnt       <= w_closing ? r_gcnt + GW'(1) : '0;
      r_gate1      <= ((w_ns == OPEN_IN) && (w_dir_nxt == UP)) || ((w_ns == OPEN_OUT) && (w_dir_nxt == DOWN));
      r_gate2      <= ((w_ns == OPEN_IN) && (w_dir_nxt == DOWN)) || ((w_ns == OPEN_OUT) && (w_dir_nxt == UP));
      r_fill       <= w_fill_side && (w_lvl_nxt < HI);
      r_drain      <= w_drain_side && (w_lvl_nxt > LO);
      r_up_grant   <= (w_ns != IDLE) && (w_dir_nxt == UP);
      r_down_grant <= (w_ns != IDLE) && (w_dir_nxt == DOWN);
    end
  end

  assign gate1_open  = r_gate1;
  assign gate2_open  = r_gate2;
  assign fill_en     = r_fill;
  assign drain_en    = r_drain;
  assign water_level = w_level;
  assign occupied    = r_occ;
  assign up_grant    = r_up_grant;
  assign down_grant  = r_down_grant;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - directed self-checking bench for lock_sequencer
module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up_req = 1'b0, down_req = 1'b0, boat_in = 1'b0, boat_out = 1'b0;
  logic       gate1_open, gate2_open, fill_en, drain_en, occupied, up_grant, down_grant;
  logic [5:0] water_level;

  logic       up_req2 = 1'b0, down_req2 = 1'b0, boat_in2 = 1'b0, boat_out2 = 1'b0;
  logic       g1_2, g2_2, fill_2, drain_2, occ_2, ug_2, dg_2;
  logic [5:0] level_2;

  int checks = 0;
  int errors = 0;
  int f, d, c, n;

  always #5 clk = ~clk;

  lock_sequencer #(.STEP_CYCLES(2), .GATE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .up_req(up_req), .down_req(down_req),
    .boat_in(boat_in), .boat_out(boat_out), .gate1_open(gate1_open), .gate2_open(gate2_open),
    .fill_en(fill_en), .drain_en(drain_en), .water_level(water_level), .occupied(occupied),
    .up_grant(up_grant), .down_grant(down_grant)
  );

  // Saturation variant: entry threshold at full scale, one-cycle pump steps
  lock_sequencer #(.HIGH_THRESH(63), .STEP_CYCLES(1), .GATE_CYCLES(3)) dut_sat (
    .clk(clk), .reset(reset), .up_req(up_req2), .down_req(down_req2),
    .boat_in(boat_in2), .boat_out(boat_out2), .gate1_open(g1_2), .gate2_open(g2_2),
    .fill_en(fill_2), .drain_en(drain_2), .water_level(level_2), .occupied(occ_2),
    .up_grant(ug_2), .down_grant(dg_2)
  );

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((gate1_open && gate2_open) || (fill_en && drain_en) ||
          ((fill_en || drain_en) && (gate1_open || gate2_open)) ||
          (gate1_open && (water_level < 6'd48)) || (gate2_open && (water_level > 6'd2))) begin
        errors++;
        $display("FAIL invariant: g1=%0b g2=%0b fill=%0b drain=%0b level=%0d", gate1_open, gate2_open,
                 fill_en, drain_en, water_level);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int which, input int bound, output int fills, output int drains,
                           output int cyc);
    fills = 0;
    drains = 0;
    cyc = 0;
    while ((cyc < bound) && !((which == 1) ? gate1_open : gate2_open)) begin
      if (fill_en) fills++;
      if (drain_en) drains++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    up_req = 1'b0; down_req = 1'b0; boat_in = 1'b0; boat_out = 1'b0;
    tick();
    tick();
    checks++;
    if ({gate1_open, gate2_open, fill_en, drain_en, occupied, up_grant, down_grant, water_level} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {gate1_open, gate2_open, fill_en, drain_en, occupied,
               up_grant, down_grant, water_level});
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({gate1_open, gate2_open, fill_en, drain_en, up_grant, down_grant} !== 6'd0) begin
      errors++;
      $display("FAIL idle_no_req: got %b want 0", {gate1_open, gate2_open, fill_en, drain_en, up_grant, down_grant});
    end
  endtask

  task automatic test_up;
    up_req = 1'b1;
    tick();
    checks++;
    if ({up_grant, down_grant, fill_en} !== 3'b101) begin
      errors++;
      $display("FAIL up_grant_fill: got %b want 101", {up_grant, down_grant, fill_en});
    end
    run_until(1, 300, f, d, c);
    checks++;
    if (c >= 300) begin errors++; $display("FAIL up_fill_timeout: cycles %0d want <300", c); end
    checks++;
    if (f !== 96 || d !== 0) begin
      errors++;
      $display("FAIL up_fill_cycles: fill %0d drain %0d want 96 0", f, d);
    end
    checks++;
    if (water_level !== 6'd48) begin errors++; $display("FAIL up_level_high: got %0d want 48", water_level); end
    boat_out = 1'b1;
    tick();
    boat_out = 1'b0;
    checks++;
    if ({gate1_open, occupied} !== 2'b10) begin
      errors++;
      $display("FAIL stray_boat_out: g1/occ got %b want 10", {gate1_open, occupied});
    end
    boat_in = 1'b1;
    up_req = 1'b0;
    tick();
    boat_in = 1'b0;
    checks++;
    if ({gate1_open, gate2_open, occupied, fill_en, drain_en} !== 5'b00100) begin
      errors++;
      $display("FAIL boat_in_close: got %b want 00100", {gate1_open, gate2_open, occupied, fill_en, drain_en});
    end
    n = 0;
    while (!drain_en && (n < 20)) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL close_in_cycles: got %0d want 3", n); end
    boat_in = 1'b1;
    tick();
    boat_in = 1'b0;
    checks++;
    if ({drain_en, occupied, gate1_open, gate2_open} !== 4'b1100) begin
      errors++;
      $display("FAIL stray_boat_in: got %b want 1100", {drain_en, occupied, gate1_open, gate2_open});
    end
    run_until(2, 300, f, d, c);
    checks++;
    if (c >= 300 || d !== 91 || f !== 0) begin
      errors++;
      $display("FAIL up_drain: cycles %0d drain %0d fill %0d want <300 91 0", c, d, f);
    end
    checks++;
    if ({water_level, occupied} !== {6'd2, 1'b1}) begin
      errors++;
      $display("FAIL up_exit_level: level %0d occ %0b want 2 1", water_level, occupied);
    end
    boat_out = 1'b1;
    tick();
    boat_out = 1'b0;
    checks++;
    if ({gate2_open, occupied, up_grant} !== 3'b001) begin
      errors++;
      $display("FAIL boat_out_close: got %b want 001", {gate2_open, occupied, up_grant});
    end
    tick();
    tick();
    checks++;
    if (up_grant !== 1'b1) begin errors++; $display("FAIL close_out_hold: grant %0b want 1", up_grant); end
    tick();
    checks++;
    if ({up_grant, down_grant, water_level} !== {2'b00, 6'd2}) begin
      errors++;
      $display("FAIL up_done_idle: got %b want 00000010", {up_grant, down_grant, water_level});
    end
  endtask

  task automatic test_both;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    up_req = 1'b1;
    down_req = 1'b1;
    tick();
    checks++;
    if ({up_grant, down_grant} !== 2'b10) begin
      errors++;
      $display("FAIL tie_first_up: got %b want 10", {up_grant, down_grant});
    end
    run_until(1, 300, f, d, c);
    boat_in = 1'b1;
    tick();
    boat_in = 1'b0;
    run_until(2, 300, f, d, c);
    checks++;
    if (c >= 300) begin errors++; $display("FAIL both_up_timeout: cycles %0d want <300", c); end
    boat_out = 1'b1;
    tick();
    boat_out = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({up_grant, down_grant} !== 2'b00) begin
      errors++;
      $display("FAIL both_idle_gap: got %b want 00", {up_grant, down_grant});
    end
    tick();
    checks++;
    if ({up_grant, down_grant, drain_en, fill_en, water_level} !== {4'b0100, 6'd2}) begin
      errors++;
      $display("FAIL tie_then_down: got %b want 0100000010", {up_grant, down_grant, drain_en, fill_en, water_level});
    end
    tick();
    checks++;
    if ({gate2_open, gate1_open} !== 2'b10) begin
      errors++;
      $display("FAIL down_no_drain_open: g2/g1 got %b want 10", {gate2_open, gate1_open});
    end
  endtask

  task automatic test_abort;
    down_req = 1'b0;
    up_req = 1'b0;
    tick();
    checks++;
    if ({gate2_open, occupied, down_grant} !== 3'b001) begin
      errors++;
      $display("FAIL abort_close: got %b want 001", {gate2_open, occupied, down_grant});
    end
    tick();
    tick();
    checks++;
    if (down_grant !== 1'b1) begin errors++; $display("FAIL abort_hold: grant %0b want 1", down_grant); end
    tick();
    checks++;
    if ({down_grant, occupied} !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle: got %b want 00", {down_grant, occupied});
    end
    f = 0;
    for (int i = 0; i < 5; i++) begin
      if (fill_en) f++;
      tick();
    end
    checks++;
    if (f !== 0 || water_level !== 6'd2) begin
      errors++;
      $display("FAIL abort_no_fill: fills %0d level %0d want 0 2", f, water_level);
    end
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    down_req = 1'b1;
    tick();
    tick();
    checks++;
    if (gate2_open !== 1'b1) begin errors++; $display("FAIL mid_gate2: got %0b want 1", gate2_open); end
    boat_in = 1'b1;
    down_req = 1'b0;
    tick();
    boat_in = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (fill_en !== 1'b1) begin errors++; $display("FAIL mid_adj_out_fill: got %0b want 1", fill_en); end
    repeat (20) tick();
    checks++;
    if (water_level !== 6'd10) begin errors++; $display("FAIL mid_level: got %0d want 10", water_level); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({gate1_open, gate2_open, fill_en, drain_en, occupied, up_grant, down_grant, water_level} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset: got %b want 0", {gate1_open, gate2_open, fill_en, drain_en, occupied,
               up_grant, down_grant, water_level});
    end
  endtask

  task automatic test_saturate;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    up_req2 = 1'b1;
    c = 0;
    while (!g1_2 && (c < 200)) begin
      tick();
      c++;
    end
    checks++;
    if (c >= 200) begin errors++; $display("FAIL sat_timeout: cycles %0d want <200", c); end
    checks++;
    if (level_2 !== 6'd63) begin errors++; $display("FAIL sat_level: got %0d want 63", level_2); end
    repeat (10) tick();
    checks++;
    if ({g1_2, fill_2, level_2} !== {2'b10, 6'd63}) begin
      errors++;
      $display("FAIL sat_hold: g1/fill/level got %b want 10111111", {g1_2, fill_2, level_2});
    end
    up_req2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up();
    test_both();
    test_abort();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Automatic controller for a single canal lock chamber.
- Arbitrates between boats waiting at the high-side gate (gate1) and the low-side gate (gate2).
- Sequences pump fill/drain, gate open/close and boat handoff, and owns the chamber water-level counter.
- Replaces manual switch/key operation of the gates and water level with a scheduled, interlocked sequence.

Parameters:
LEVEL_MAX, 63, full-scale water level; level is 6 bits wide.
HIGH_THRESH, 48, level at or above which gate1 may open.
LOW_THRESH, 2, level at or below which gate2 may open.
STEP_CYCLES, 4, clock cycles per one-unit level change while pumping; must be >=1.
GATE_CYCLES, 3, cycles spent in each gate-closing state.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
up_req  in  1  level: boat waiting at gate1 (high side), travelling downstream.
down_req  in  1  level: boat waiting at gate2 (low side), travelling upstream.
boat_in  in  1  single-cycle pulse: boat fully inside the chamber.
boat_out  in  1  single-cycle pulse: boat has cleared the exit gate.
gate1_open  out  1  gate1 open command.
gate2_open  out  1  gate2 open command.
fill_en  out  1  pump filling chamber.
drain_en  out  1  pump draining chamber.
water_level  out  6  current chamber level.
occupied  out  1  boat inside chamber.
up_grant  out  1  current cycle serves up_req.
down_grant  out  1  current cycle serves down_req.

Behaviour:
- Reset:
  - state IDLE; all outputs 0; water_level 0.
  - last_dir = DOWN, so the first tie is granted to UP.
  - Internal step counter is cleared.
  - Reset mid-operation aborts immediately: gates close and pumps stop.
- Direction: dir = UP serves up_req (enter gate1, exit gate2). dir = DOWN serves down_req (enter gate2, exit gate1).
- Entry side / exit side:
  - Entry side is gate1 at HIGH for UP, gate2 at LOW for DOWN.
  - Exit side is the opposite gate and level.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the direction opposite last_dir (round-robin). Latch dir and last_dir.
  - If neither is high, stay in IDLE.
  - Next state is ADJ_IN.
- ADJ_IN:
  - Fill (UP) until level >= HIGH_THRESH, or drain (DOWN) until level <= LOW_THRESH.
  - If the level already satisfies the target, no pump cycle occurs.
  - Next state is OPEN_IN.
- OPEN_IN: entry gate open.
  - boat_in -> set occupied, go to CLOSE_IN.
  - The granted request dropping without boat_in -> go to CLOSE_IN with occupied = 0 (abort).
- CLOSE_IN:
  - Both gates closed for GATE_CYCLES cycles.
  - Then ADJ_OUT if occupied, else IDLE.
- ADJ_OUT: pump toward the exit threshold (drain for UP, fill for DOWN), then OPEN_OUT.
- OPEN_OUT: exit gate open; wait for boat_out, then clear occupied and go to CLOSE_OUT.
- CLOSE_OUT: gates closed for GATE_CYCLES cycles, then IDLE.
- Level counter:
  - While fill_en, increment every STEP_CYCLES cycles, saturating at LEVEL_MAX.
  - While drain_en, decrement every STEP_CYCLES cycles, saturating at 0.
  - The step counter clears whenever the pump is off.
  - water_level is registered.
- Pump and gate outputs:
  - All are registered Moore outputs decoded from state.
  - The gate opens on the cycle after the threshold is met, so pump and gate are never active together.
- Grants: up_grant/down_grant are high from the ADJ_IN entry through CLOSE_OUT for the latched dir.
- Invariants, which must hold every cycle:
  - Never gate1_open and gate2_open together.
  - Never fill_en and drain_en together.
  - No pump while any gate is open.
  - Gate1 open implies level >= HIGH_THRESH; gate2 open implies level <= LOW_THRESH.
- Ignored inputs:
  - boat_in is ignored outside OPEN_IN; boat_out is ignored outside OPEN_OUT.
  - If both pulse in the same cycle, only the one valid for the current state acts.
  - Request changes outside IDLE and OPEN_IN are ignored.

Decomposition:
- Package lock_pkg holds:
  - State enum: IDLE, ADJ_IN, OPEN_IN, CLOSE_IN, ADJ_OUT, OPEN_OUT, CLOSE_OUT.
  - dir_t enum: UP, DOWN.
  - Level width constant 6.
- Sub-module water_level_ctr holds the level register, step prescaler and saturation.
  - Inputs: clk, reset, fill_en, drain_en.
  - Output: level.

Test Plan (STEP_CYCLES=2, GATE_CYCLES=3):
- Reset then up_req=1 alone:
  - fill_en for 96 cycles until level = 48, then gate1_open.
  - boat_in -> gates closed 3 cycles, then drain to 2, then gate2_open.
  - boat_out -> IDLE, level = 2.
- up_req and down_req both high from reset:
  - UP is served first; DOWN is granted in the following IDLE.
  - DOWN skips draining because level = 2 <= LOW_THRESH; gate2 opens 1 cycle after ADJ_IN.
- Abort: down_req drops while gate2 is open without boat_in:
  - gate closes for 3 cycles, back to IDLE, occupied = 0, no fill.
- Saturation: force fill past the threshold (HIGH_THRESH=63 variant):
  - level stops at 63 and never wraps to 0.
- Reset asserted during ADJ_OUT mid-fill:
  - all outputs 0 and level = 0 immediately, asynchronously, without waiting for clk.
- Stray pulses: boat_out in OPEN_IN and boat_in in ADJ_OUT have no effect.
- Every test: assert the invariants every cycle.
